// File: rtl/ksz8851_bus_engine_if.sv
`timescale 1ns/1ps
// Command/status handshake between the transmission sequencer (master)
// and the KSZ8851 bus-cycle engine (slave).
interface ksz8851_bus_engine_if;
  logic        NewCommand;
  logic        WR;
  logic [7:0]  offset;
  logic        length;
  logic        Dummy_Write;
  logic [15:0] writeData;
  logic [3:0]  state;
  logic [15:0] readData;

  modport master (
    output NewCommand, WR, offset, length, Dummy_Write, writeData,
    input  state, readData
  );

  modport slave (
    input  NewCommand, WR, offset, length, Dummy_Write, writeData,
    output state, readData
  );
endinterface

// File: rtl/ksz8851_bus_engine.sv
`timescale 1ns/1ps
// KSZ8851 host-bus cycle engine: turns sequencer commands into address,
// read and write strobe cycles on the CMD/CSn/RDn/WRn/SD pins.
module ksz8851_bus_engine (
  input  logic               clk40m,
  input  logic               reset,
  ksz8851_bus_engine_if.slave bus,
  output logic               ETH_CMD,
  output logic               ETH_CSn,
  output logic               ETH_RDn,
  output logic               ETH_WRn,
  inout  wire  [15:0]        ETH_SD
);

  typedef enum logic [3:0] {
    ADDR0  = 4'b0000,
    ADDR1  = 4'b0001,
    ADDR2  = 4'b0010,
    READ0  = 4'b0011,
    READ1  = 4'b0100,
    READ2  = 4'b0101,
    WRITE0 = 4'b0110,
    WRITE1 = 4'b0111,
    WRITE2 = 4'b1000,
    WAIT   = 4'b1001
  } state_e;

  // Held as a plain vector so the unused codes 1010-1111 stay representable
  logic [3:0]  state_r;
  logic [3:0]  state_nx;
  logic        wr_q;
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic [15:0] read_q;
  logic        sd_oe;

  logic [3:0]  be;
  logic [15:0] addr_word;
  logic        csn_nx;
  logic        cmd_nx;
  logic        rdn_nx;
  logic        wrn_nx;
  logic        oe_nx;

  function automatic logic [3:0] after_cycle(input logic nc, input logic dw);
    if (!nc)
      return WAIT;
    else if (dw)
      return WRITE0;
    else
      return ADDR0;
  endfunction

  always_comb begin
    if (bus.length)
      be = bus.offset[1] ? 4'b1100 : 4'b0011;
    else
      be = 4'b0001 << bus.offset[1:0];
    addr_word = {be, 4'b0000, bus.offset[7:2], 2'b00};
  end

  always_comb begin
    state_nx = WAIT;
    case (state_r)
      WAIT:    state_nx = after_cycle(bus.NewCommand, bus.Dummy_Write);
      ADDR0:   state_nx = ADDR1;
      ADDR1:   state_nx = ADDR2;
      ADDR2:   state_nx = wr_q ? WRITE0 : READ0;
      READ0:   state_nx = READ1;
      READ1:   state_nx = READ2;
      READ2:   state_nx = after_cycle(bus.NewCommand, bus.Dummy_Write);
      WRITE0:  state_nx = WRITE1;
      WRITE1:  state_nx = WRITE2;
      WRITE2:  state_nx = after_cycle(bus.NewCommand, bus.Dummy_Write);
      default: state_nx = WAIT;
    endcase
  end

  // Pins are decoded from the next state so they switch on the same edge as state
  always_comb begin
    csn_nx = 1'b0;
    cmd_nx = 1'b0;
    rdn_nx = 1'b1;
    wrn_nx = 1'b1;
    oe_nx  = 1'b0;
    case (state_nx)
      WAIT:   csn_nx = 1'b1;
      ADDR0:  cmd_nx = 1'b1;
      ADDR1: begin
        cmd_nx = 1'b1;
        wrn_nx = 1'b0;
        oe_nx  = 1'b1;
      end
      ADDR2: begin
        cmd_nx = 1'b1;
        oe_nx  = 1'b1;
      end
      READ0, READ1: rdn_nx = 1'b0;
      READ2:  rdn_nx = 1'b1;
      WRITE0: oe_nx  = 1'b0;
      WRITE1: begin
        wrn_nx = 1'b0;
        oe_nx  = 1'b1;
      end
      WRITE2: oe_nx  = 1'b1;
      default: csn_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk40m or posedge reset) begin
    if (reset) begin
      state_r <= WAIT;
      ETH_CSn <= 1'b1;
      ETH_CMD <= 1'b0;
      ETH_RDn <= 1'b1;
      ETH_WRn <= 1'b1;
      sd_oe   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 16'h0000;
      data_q  <= 16'h0000;
      read_q  <= 16'h0000;
    end else begin
      state_r <= state_nx;
      ETH_CSn <= csn_nx;
      ETH_CMD <= cmd_nx;
      ETH_RDn <= rdn_nx;
      ETH_WRn <= wrn_nx;
      sd_oe   <= oe_nx;
      if (state_r == ADDR0) begin
        wr_q   <= bus.WR;
        addr_q <= addr_word;
      end
      if (state_r == WRITE0)
        data_q <= bus.writeData;
      // Captured while RDn is still low, on the way into Read2
      if (state_r == READ1)
        read_q <= ETH_SD;
    end
  end

  assign ETH_SD       = sd_oe ? (ETH_CMD ? addr_q : data_q) : 16'hzzzz;
  assign bus.state    = state_r;
  assign bus.readData = read_q;

endmodule

// File: tb/tb_ksz8851_bus_engine.sv
`timescale 1ns/1ps
// Directed bench for ksz8851_bus_engine with a minimal KSZ8851 pin model
// that answers reads and logs every WRn pulse.
module tb_ksz8851_bus_engine;

  logic        clk40m = 1'b0;
  logic        reset;
  logic        eth_cmd;
  logic        eth_csn;
  logic        eth_rdn;
  logic        eth_wrn;
  wire  [15:0] eth_sd;
  logic [15:0] dev_rdata;
  logic        dev_drive;
  logic [16:0] wr_log[$];
  int          rd_low_count = 0;
  int          compared = 0;
  int          mismatched = 0;
  int          log_base;
  int          rd_base;
  logic [15:0] burst_words [6];

  ksz8851_bus_engine_if bus_if ();

  ksz8851_bus_engine dut (
    .clk40m  (clk40m),
    .reset   (reset),
    .bus     (bus_if.slave),
    .ETH_CMD (eth_cmd),
    .ETH_CSn (eth_csn),
    .ETH_RDn (eth_rdn),
    .ETH_WRn (eth_wrn),
    .ETH_SD  (eth_sd)
  );

  always #12.5 clk40m = ~clk40m;

  assign dev_drive = !eth_csn && !eth_rdn && !eth_cmd;
  assign eth_sd    = dev_drive ? dev_rdata : 16'hzzzz;

  // Each log entry is {CMD, SD} sampled mid-way through a WRn-low clock
  always @(negedge clk40m) begin
    if (!eth_csn && !eth_wrn)
      wr_log.push_back({eth_cmd, eth_sd});
    if (!eth_csn && !eth_rdn)
      rd_low_count++;
  end

  task automatic tick();
    @(posedge clk40m);
    #3;
  endtask

  task automatic apply_stimulus(input logic nc, input logic dw, input logic wr,
                                input logic [7:0] off, input logic len,
                                input logic [15:0] wd);
    bus_if.NewCommand  = nc;
    bus_if.Dummy_Write = dw;
    bus_if.WR          = wr;
    bus_if.offset      = off;
    bus_if.length      = len;
    bus_if.writeData   = wd;
  endtask

  task automatic check_output(input string tag, input logic [16:0] observed,
                              input logic [16:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    burst_words[0] = 16'h8000;
    burst_words[1] = 16'h0040;
    burst_words[2] = 16'h2345;
    burst_words[3] = 16'h2345;
    burst_words[4] = 16'h2345;
    burst_words[5] = 16'h2345;
    dev_rdata = 16'h0000;
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
    #40;
    check_output("rst_state", {13'd0, bus_if.state}, 17'h9);
    check_output("rst_csn", {16'd0, eth_csn}, 17'h1);
    check_output("rst_cmd", {16'd0, eth_cmd}, 17'h0);
    check_output("rst_rdn", {16'd0, eth_rdn}, 17'h1);
    check_output("rst_wrn", {16'd0, eth_wrn}, 17'h1);
    check_output("rst_rdata", {1'b0, bus_if.readData}, 17'h0000);
    tick();
    reset = 1'b0;
    tick();
    check_output("idle_wait", {13'd0, bus_if.state}, 17'h9);

    $display("[TB] word read at 0x78");
    log_base = wr_log.size();
    rd_base  = rd_low_count;
    dev_rdata = 16'h1234;
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h78, 1'b1, 16'h0000);
    tick();
    check_output("rd_addr0_state", {13'd0, bus_if.state}, 17'h0);
    check_output("rd_addr0_csn", {16'd0, eth_csn}, 17'h0);
    check_output("rd_addr0_cmd", {16'd0, eth_cmd}, 17'h1);
    tick();
    check_output("rd_addr1_wrn", {16'd0, eth_wrn}, 17'h0);
    check_output("rd_addr1_sd", {1'b0, eth_sd}, 17'h3078);
    tick();
    check_output("rd_addr2_wrn", {16'd0, eth_wrn}, 17'h1);
    tick();
    check_output("rd_read0_rdn", {16'd0, eth_rdn}, 17'h0);
    check_output("rd_read0_cmd", {16'd0, eth_cmd}, 17'h0);
    tick();
    bus_if.NewCommand = 1'b0;
    tick();
    check_output("rd_read2_state", {13'd0, bus_if.state}, 17'h5);
    check_output("rd_read2_rdata", {1'b0, bus_if.readData}, 17'h1234);
    check_output("rd_read2_rdn", {16'd0, eth_rdn}, 17'h1);
    tick();
    check_output("rd_end_state", {13'd0, bus_if.state}, 17'h9);
    check_output("rd_end_csn", {16'd0, eth_csn}, 17'h1);
    check_output("rd_wr_pulses", 17'(wr_log.size() - log_base), 17'd1);
    check_output("rd_addr_word", wr_log[log_base], {1'b1, 16'h3078});
    check_output("rd_rdn_clocks", 17'(rd_low_count - rd_base), 17'd2);

    $display("[TB] back-to-back writes at 0x90 and 0x82");
    log_base = wr_log.size();
    apply_stimulus(1'b1, 1'b0, 1'b1, 8'h90, 1'b1, 16'h0000);
    tick();
    tick();
    tick();
    tick();
    check_output("wr_write0_state", {13'd0, bus_if.state}, 17'h6);
    tick();
    check_output("wr_write1_wrn", {16'd0, eth_wrn}, 17'h0);
    tick();
    bus_if.offset    = 8'h82;
    bus_if.writeData = 16'h5A5A;
    tick();
    check_output("wr_no_wait_state", {13'd0, bus_if.state}, 17'h0);
    tick();
    tick();
    tick();
    tick();
    tick();
    bus_if.NewCommand = 1'b0;
    tick();
    check_output("wr_end_state", {13'd0, bus_if.state}, 17'h9);
    check_output("wr_pulses", 17'(wr_log.size() - log_base), 17'd4);
    check_output("wr_addr_a", wr_log[log_base],     {1'b1, 16'h3090});
    check_output("wr_data_a", wr_log[log_base + 1], {1'b0, 16'h0000});
    check_output("wr_addr_b", wr_log[log_base + 2], {1'b1, 16'hC080});
    check_output("wr_data_b", wr_log[log_base + 3], {1'b0, 16'h5A5A});

    $display("[TB] byte read at 0x81");
    log_base = wr_log.size();
    dev_rdata = 16'h00AB;
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h81, 1'b0, 16'h0000);
    repeat (5) tick();
    bus_if.NewCommand = 1'b0;
    tick();
    check_output("byte_rdata", {1'b0, bus_if.readData}, 17'h00AB);
    tick();
    check_output("byte_end_state", {13'd0, bus_if.state}, 17'h9);
    check_output("byte_addr_word", wr_log[log_base], {1'b1, 16'h2080});

    $display("[TB] dummy write burst");
    log_base = wr_log.size();
    apply_stimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, burst_words[0]);
    tick();
    for (int i = 0; i < 6; i++) begin
      bus_if.writeData = burst_words[i];
      check_output($sformatf("burst_state_%0d", i), {13'd0, bus_if.state}, 17'h6);
      check_output($sformatf("burst_cmd_%0d", i), {16'd0, eth_cmd}, 17'h0);
      tick();
      tick();
      if (i == 5)
        bus_if.NewCommand = 1'b0;
      tick();
    end
    check_output("burst_end_state", {13'd0, bus_if.state}, 17'h9);
    check_output("burst_pulses", 17'(wr_log.size() - log_base), 17'd6);
    for (int i = 0; i < 6; i++)
      check_output($sformatf("burst_word_%0d", i), wr_log[log_base + i],
                   {1'b0, burst_words[i]});

    $display("[TB] reset during Read1");
    rd_base = rd_low_count;
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h78, 1'b1, 16'h0000);
    repeat (5) tick();
    bus_if.NewCommand = 1'b0;
    reset = 1'b1;
    #1;
    check_output("mid_rst_state", {13'd0, bus_if.state}, 17'h9);
    check_output("mid_rst_csn", {16'd0, eth_csn}, 17'h1);
    check_output("mid_rst_rdn", {16'd0, eth_rdn}, 17'h1);
    check_output("mid_rst_cmd", {16'd0, eth_cmd}, 17'h0);
    check_output("mid_rst_wrn", {16'd0, eth_wrn}, 17'h1);
    check_output("mid_rst_rdata", {1'b0, bus_if.readData}, 17'h0000);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check_output("post_rst_state", {13'd0, bus_if.state}, 17'h9);
    check_output("post_rst_rdn", {16'd0, eth_rdn}, 17'h1);
    check_output("post_rst_rd_clocks", 17'(rd_low_count - rd_base), 17'd1);

    $display("[TB] illegal state recovery");
    force dut.state_r = 4'b1100;
    #1;
    release dut.state_r;
    tick();
    check_output("illegal_recover", {13'd0, bus_if.state}, 17'h9);
    check_output("illegal_csn", {16'd0, eth_csn}, 17'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ksz8851_bus_engine.md
# ksz8851_bus_engine

Host-bus cycle engine for the KSZ8851 Ethernet controller. It sits directly downstream of the transmission sequencer. It consumes that sequencer's command fields (NewCommand, WR, offset, length, writeData, Dummy_Write) and runs the matching KSZ8851 address, read and write strobe cycles on the chip pins. It returns its current bus state and the captured read data, and the sequencer paces its own steps on that state.

## Interface
- Parameters: none.
- clk40m  in  1  system clock, 40 MHz; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- NewCommand  in  1  request another bus cycle; sampled in Wait, Read2 and Write2.
- WR  in  1  1 = register write, 0 = register read; sampled in Addr0.
- offset  in  8  KSZ8851 register byte offset; sampled in Addr0.
- length  in  1  1 = 16-bit word access, 0 = byte access; sampled in Addr0.
- Dummy_Write  in  1  1 = data-only write with no address phase (QMU TXQ burst).
- writeData  in  16  write data; sampled in Write0.
- state  out  4  current bus state (encoding below).
- readData  out  16  last captured read word, held until the next capture.
- ETH_CMD  out  1  KSZ8851 CMD pin: 1 = address phase, 0 = data phase.
- ETH_CSn  out  1  chip select, active low.
- ETH_RDn  out  1  read strobe, active low.
- ETH_WRn  out  1  write strobe, active low.
- ETH_SD  inout  16  shared address/data bus; hi-Z when this block is not driving it.

## Operation
- State encoding:
  - Addr0 = 0000, Addr1 = 0001, Addr2 = 0010
  - Read0 = 0011, Read1 = 0100, Read2 = 0101
  - Write0 = 0110, Write1 = 0111, Write2 = 1000
  - Wait = 1001
- Transitions:
  - Wait: if NewCommand = 0, stay in Wait. If NewCommand = 1, go to Write0 when Dummy_Write = 1, otherwise to Addr0.
  - Addr0 → Addr1 → Addr2.
  - Addr2 → Write0 if the latched WR = 1, else Read0.
  - Read0 → Read1 → Read2. Write0 → Write1 → Write2.
  - Read2 and Write2 follow the same rule as Wait: NewCommand = 0 → Wait; NewCommand = 1 → Write0 if Dummy_Write = 1, else Addr0.
  - Unused encodings 1010–1111 → Wait on the next edge.
- Address word (latched on the Addr0 → Addr1 edge, together with WR):
  - Layout: {BE[3:0], 4'b0000, offset[7:2], 2'b00}.
  - Word access (length = 1): BE = offset[1] ? 1100 : 0011.
  - Byte access (length = 0): BE = 0001 << offset[1:0].
- Write data is latched from writeData on the Write0 → Write1 edge.
- Pin values by state (all pins are registered and change on the same edge the state changes):
  - Wait: CSn = 1, CMD = 0, RDn = 1, WRn = 1, SD hi-Z.
  - Addr0: CSn = 0, CMD = 1, SD hi-Z, strobes high.
  - Addr1: CMD = 1, SD = address word, WRn = 0.
  - Addr2: CMD = 1, SD = address word, WRn = 1.
  - Read0 and Read1: CMD = 0, SD hi-Z, RDn = 0.
  - Read2: RDn = 1.
  - Write0: CMD = 0, SD hi-Z.
  - Write1: SD = latched data, WRn = 0.
  - Write2: SD = latched data, WRn = 1.
  - CSn = 0 in every state except Wait.
- readData is loaded from ETH_SD on the Read1 → Read2 edge, while RDn is still low. It is unchanged at all other times.

## Timing
- Reset values: state = Wait, readData = 0x0000, CSn = 1, CMD = 0, RDn = 1, WRn = 1, SD hi-Z, address and data latches = 0.
- Reset asserted mid-cycle: the block abandons the cycle immediately (asynchronously) and returns to reset values. It must not issue a partial strobe after reset deasserts.
- Cycle lengths:
  - Addressed read: 6 clocks from Addr0 to Read2 end.
  - Addressed write: 6 clocks.
  - Dummy write: 3 clocks per word; back-to-back Write0–Write2 loops with no Wait while NewCommand and Dummy_Write stay high.
- readData is valid from the first clock of Read2 onward, so it is usable by the sequencer in Addr0 or Wait.
- Upstream must present offset, length and WR by Addr0, and writeData by Write0. The sequencer updates these in Read2/Write2, which meets this.
- Strobe margins:
  - Address and data are driven one clock before the WRn rising edge, and held one clock after it.
  - RDn is low for 2 clocks (50 ns).
- SD turnaround: at least one hi-Z clock between the address phase and read data (Read0), and between any read and a following drive (Write0 or Addr0 is hi-Z).

## Test plan
- Read of offset 0x78, length = 1, device model returns 0x1234:
  - Address word 0x3078 with one WRn pulse.
  - RDn low for 2 clocks.
  - readData = 0x1234 on entering Read2.
  - NewCommand dropped during Read1 → state returns to Wait.
- Write of offset 0x90, data 0x0000, then offset 0x82 with NewCommand held high:
  - Address words 0x3090, then 0xC080.
  - Second cycle goes Write2 → Addr0 with no Wait in between.
- Byte read at offset 0x81, length = 0: address word 0x2080.
- Dummy burst of 0x8000, 0x0040 and 4× 0x2345 with Dummy_Write = 1:
  - Six Write0–2 loops, CMD = 0 throughout, no address phase.
  - Device model captures all six words in order.
- Reset pulse during Read1:
  - All pins return to reset values in the same cycle and SD goes hi-Z.
  - After release, state = Wait until NewCommand is asserted.
- Force an illegal state value of 1100: the block recovers to Wait on the next edge.
